// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem reads, prefetch FIFO feeding the IR.
// Optional FETCH_PERF_CNT_EN adds saturating fetch_cnt/flush_cnt outputs.
module fetch_unit #(
  parameter int                 ADDR_W   = 14,
  parameter int                 INS_W    = 19,
  parameter int                 DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_valid,
  input  logic [INS_W-1:0]  imem_rdata,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] ins_pc,
  output logic              ins_valid,
  input  logic              take,
  input  logic              redirect,
`ifdef FETCH_PERF_CNT_EN
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       flush_cnt
`else
  input  logic [ADDR_W-1:0] redirect_pc
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshake: a request transfers on a cycle with imem_req=1 and imem_ready=1;
  // exactly one imem_valid pulse answers it, honoured only while in S_WAIT.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc, pc_next, req_pc, req_pc_next;
  logic              drop, drop_next;
  logic [CW-1:0]     count, count_next;
  logic [PW-1:0]     head, tail;
  logic              push, pop;

  logic [INS_W-1:0]  mem_ins [DEPTH];
  logic [ADDR_W-1:0] mem_pc  [DEPTH];

  always_comb begin
    push        = (state == S_WAIT) && imem_valid && !drop && !redirect;
    pop         = take && (count != '0) && !redirect;
    count_next  = redirect ? '0 : (count + CW'(push) - CW'(pop));
    state_next  = state;
    pc_next     = pc;
    req_pc_next = req_pc;
    drop_next   = drop;
    case (state)
      S_IDLE: if (count_next < DEPTH_C) state_next = S_REQ;
      S_REQ: begin
        if (imem_ready) begin
          req_pc_next = pc;
          pc_next     = pc + ADDR_W'(1);
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_valid) begin
          drop_next  = 1'b0;
          state_next = (count_next < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // A redirect overrides the above; a request already accepted must still
    // drain its response, which is then thrown away via drop.
    if (redirect) begin
      pc_next = redirect_pc;
      case (state)
        S_REQ: begin
          state_next = imem_ready ? S_WAIT : S_REQ;
          drop_next  = imem_ready;
        end
        S_WAIT: begin
          state_next = imem_valid ? S_REQ : S_WAIT;
          drop_next  = !imem_valid;
        end
        default: begin
          state_next = S_REQ;
          drop_next  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      drop   <= 1'b0;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      req_pc <= req_pc_next;
      drop   <= drop_next;
      count  <= count_next;
      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ins[tail] <= imem_rdata;
      mem_pc[tail]  <= req_pc;
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;
  assign ins_valid = (count != '0);
  assign ins       = ins_valid ? mem_ins[head] : '0;
  assign ins_pc    = ins_valid ? mem_pc[head]  : '0;

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push && (fetch_cnt != 16'hFFFF))     fetch_cnt <= fetch_cnt + 16'd1;
      if (redirect && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fill, streaming, PC wrap, redirects and mid-flight reset.
// Memory responses are driven by hand with a fixed word pattern {5'h15, addr}.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [13:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [18:0] imem_rdata;
  logic [18:0] ins;
  logic [13:0] ins_pc;
  logic        ins_valid;
  logic        take;
  logic        redirect;
  logic [13:0] redirect_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid),
    .take        (take),
    .redirect    (redirect),
`ifdef FETCH_PERF_CNT_EN
    .redirect_pc (redirect_pc),
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`else
    .redirect_pc (redirect_pc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] word(input logic [13:0] a);
    return {5'h15, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From S_REQ: accept the request for address a, then return its word one cycle later.
  task automatic fetch_one(input logic [13:0] a, input logic tk_acc, input logic tk_val);
    chk("req_high", 32'(imem_req), 32'd1);
    chk("req_addr", 32'(imem_addr), 32'(a));
    imem_ready = 1'b1;
    take       = tk_acc;
    tick();
    imem_ready = 1'b0;
    take       = 1'b0;
    chk("wait_req_low", 32'(imem_req), 32'd0);
    imem_valid = 1'b1;
    imem_rdata = word(a);
    take       = tk_val;
    tick();
    imem_valid = 1'b0;
    imem_rdata = '0;
    take       = 1'b0;
  endtask

  task automatic head_is(input string tag, input logic [13:0] a);
    chk({tag, "_valid"}, 32'(ins_valid), 32'd1);
    chk({tag, "_pc"}, 32'(ins_pc), 32'(a));
    chk({tag, "_ins"}, 32'(ins), 32'(word(a)));
  endtask

  task automatic empty_is(input string tag);
    chk({tag, "_valid"}, 32'(ins_valid), 32'd0);
    chk({tag, "_ins"}, 32'(ins), 32'd0);
    chk({tag, "_pc"}, 32'(ins_pc), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
    take = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    empty_is("rst");
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Fill: idle one cycle, then two fetches fill the FIFO and requests stop.
    chk("idle_req", 32'(imem_req), 32'd0);
    tick();
    fetch_one(14'h0000, 1'b0, 1'b0);
    head_is("fill1", 14'h0000);
    fetch_one(14'h0001, 1'b0, 1'b0);
    head_is("fill2", 14'h0000);
    chk("full_req", 32'(imem_req), 32'd0);
    tick();
    tick();
    chk("full_req_hold", 32'(imem_req), 32'd0);
    head_is("full_hold", 14'h0000);

    // Pop one: frees a slot, fetching resumes at 2.
    take = 1'b1;
    tick();
    take = 1'b0;
    head_is("pop1", 14'h0001);

    // Streaming with take held: each word replaces the previous head.
    fetch_one(14'h0002, 1'b1, 1'b1);
    head_is("stream2", 14'h0002);
    fetch_one(14'h0003, 1'b1, 1'b1);
    head_is("stream3", 14'h0003);
    fetch_one(14'h0004, 1'b1, 1'b1);
    head_is("stream4", 14'h0004);

    // Simultaneous push and pop: count stays at one.
    fetch_one(14'h0005, 1'b0, 1'b1);
    head_is("pushpop", 14'h0005);

    // Redirect from S_REQ (no ready), then stream across the PC wrap.
    redirect = 1'b1; redirect_pc = 14'h3FFE;
    tick();
    redirect = 1'b0;
    empty_is("redir_req");
    fetch_one(14'h3FFE, 1'b1, 1'b1);
    head_is("wrap_3ffe", 14'h3FFE);
    fetch_one(14'h3FFF, 1'b1, 1'b1);
    head_is("wrap_3fff", 14'h3FFF);
    fetch_one(14'h0000, 1'b1, 1'b1);
    head_is("wrap_0000", 14'h0000);

    // Redirect twice in S_WAIT; the stale response arrives afterwards and is dropped.
    chk("pre_wait_addr", 32'(imem_addr), 32'h0001);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 14'h0080;
    tick();
    redirect_pc = 14'h0100;
    tick();
    redirect = 1'b0;
    empty_is("redir_wait");
    chk("redir_wait_req", 32'(imem_req), 32'd0);
    imem_valid = 1'b1; imem_rdata = word(14'h0001);
    tick();
    imem_valid = 1'b0; imem_rdata = '0;
    empty_is("stale_drop");
    fetch_one(14'h0100, 1'b0, 1'b0);
    head_is("after_wait_redir", 14'h0100);

    // Redirect together with imem_ready (take in the same cycle is ignored).
    imem_ready = 1'b1; take = 1'b1; redirect = 1'b1; redirect_pc = 14'h0200;
    tick();
    imem_ready = 1'b0; take = 1'b0; redirect = 1'b0;
    empty_is("redir_ready");
    chk("redir_ready_req", 32'(imem_req), 32'd0);
    imem_valid = 1'b1; imem_rdata = word(14'h0101);
    tick();
    imem_valid = 1'b0; imem_rdata = '0;
    empty_is("redir_ready_drop");
    fetch_one(14'h0200, 1'b0, 1'b0);
    head_is("after_ready_redir", 14'h0200);

    // Redirect together with imem_valid.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    imem_valid = 1'b1; imem_rdata = word(14'h0201);
    redirect = 1'b1; redirect_pc = 14'h0300;
    tick();
    imem_valid = 1'b0; imem_rdata = '0; redirect = 1'b0;
    empty_is("redir_valid");
    chk("redir_valid_req", 32'(imem_req), 32'd1);
    chk("redir_valid_addr", 32'(imem_addr), 32'h0300);
    tick();
    empty_is("redir_valid_hold");
    fetch_one(14'h0300, 1'b0, 1'b0);
    head_is("after_valid_redir", 14'h0300);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", 32'(fetch_cnt), 32'd12);
    chk("flush_cnt", 32'(flush_cnt), 32'd5);
`endif

    // Reset while in S_WAIT, then stray valid pulses after release.
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("pre_rst_wait_req", 32'(imem_req), 32'd0);
    rst = 1'b1;
    #1;
    empty_is("async_rst");
    chk("async_rst_addr", 32'(imem_addr), 32'd0);
    chk("async_rst_req", 32'(imem_req), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst2_fetch_cnt", 32'(fetch_cnt), 32'd0);
    chk("rst2_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    tick();
    rst = 1'b0;
    imem_valid = 1'b1; imem_rdata = word(14'h0301);
    tick();
    empty_is("stray_idle");
    tick();
    imem_valid = 1'b0; imem_rdata = '0;
    empty_is("stray_req");
    fetch_one(14'h0000, 1'b0, 1'b0);
    head_is("after_rst", 14'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the instruction register.
- Holds the 14-bit program counter and issues single-outstanding read requests to instruction memory.
- Buffers returned 19-bit instruction words in a small prefetch FIFO.
- Presents the FIFO head to the instruction register; the consumer's `take` pulse is the same strobe that drives `load_IR`.
- Handles control-flow redirects (BEQ/BNE/JMP/CALL) by flushing the FIFO and discarding any in-flight response.

Parameters:
- ADDR_W, 14: PC / memory address width.
- INS_W, 19: instruction word width.
- DEPTH, 2: prefetch FIFO entries, power of two, minimum 2.
- RESET_PC, 14'd0: PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req  out  1  read request valid.
- imem_addr  out  ADDR_W  read address; equals current PC.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_valid  in  1  read data valid, one pulse per accepted request.
- imem_rdata  in  INS_W  read data.
- ins  out  INS_W  FIFO head instruction; 0 when empty.
- ins_pc  out  ADDR_W  address of the FIFO head; 0 when empty.
- ins_valid  out  1  FIFO non-empty.
- take  in  1  consumer pops the head; drives `load_IR`.
- redirect  in  1  control-flow change.
- redirect_pc  in  ADDR_W  new PC when redirect=1.

Behaviour:
- Reset (asynchronous, active-high):
  - pc=RESET_PC, state=S_IDLE, FIFO count=0, drop=0.
  - imem_req=0, ins=0, ins_pc=0, ins_valid=0.
- FSM states: S_IDLE, S_REQ, S_WAIT.
  - S_IDLE: imem_req=0. Move to S_REQ when the next-cycle FIFO count < DEPTH.
  - S_REQ: imem_req=1, imem_addr=pc. On imem_ready: req_pc<=pc, pc<=pc+1, go to S_WAIT.
  - S_WAIT: imem_req=0, waiting for imem_valid. On imem_valid:
    - if drop=0, push {imem_rdata, req_pc}; if drop=1, discard the data and clear drop.
    - Then go to S_REQ if the post-update count < DEPTH, else S_IDLE.
- imem_valid is ignored outside S_WAIT. At most one request is outstanding.
- PC increments modulo 2^ADDR_W: 14'h3FFF wraps to 14'h0000.
- FIFO:
  - ins, ins_pc and ins_valid come from registers/head pointer; no combinational path from imem_rdata.
  - A pushed word is visible on the cycle after imem_valid.
  - take with ins_valid=1 pops the head.
  - take with ins_valid=0 is ignored; no underflow.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Overflow is impossible by construction: a request is issued only when count < DEPTH.
- Latency: reset released at cycle 0 (S_IDLE), S_REQ at cycle 1. With imem_ready=1 and imem_valid at cycle 2, ins_valid=1 at cycle 3.
- Redirect has priority over everything else. In any state:
  - count<=0; take in the same cycle is ignored.
  - pc<=redirect_pc.
  - From S_IDLE or S_REQ without imem_ready: go to S_REQ.
  - From S_REQ with imem_ready in the same cycle: the old request is accepted; go to S_WAIT with drop=1.
  - From S_WAIT without imem_valid: stay in S_WAIT with drop=1.
  - From S_WAIT with imem_valid in the same cycle: discard the data, go to S_REQ, drop=0.
  - A second redirect while drop=1 only updates pc; the FIFO stays empty.
- Reset mid-transaction: state is abandoned immediately. A late imem_valid arriving in S_IDLE/S_REQ after reset is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt (out, 16) and flush_cnt (out, 16), both reset to 0.
  - fetch_cnt increments on each pushed word.
  - flush_cnt increments on each redirect cycle.
  - Both saturate at 16'hFFFF.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset, imem_ready=1, 1-cycle memory latency, take held 0 → addresses 0,1 requested; FIFO fills with 2 entries; imem_req stays 0 afterwards; ins_pc=0, ins_valid=1.
- Continuous take=1 with a 1-cycle memory → ins_pc sequence 0,1,2,3…; no skipped or duplicated words.
- pc=14'h3FFE, streaming → requests 3FFE, 3FFF, 0000; ins_pc wraps correctly.
- Redirect to 14'h0100 while in S_WAIT; old response returns 2 cycles later → that word is discarded; next request addr=0100; first ins_pc=0100.
- Redirect in the same cycle as imem_ready, and separately in the same cycle as imem_valid → FIFO empty the next cycle; no stale word appears; next request addr=redirect_pc.
- Assert rst while in S_WAIT, then pulse imem_valid after release → outputs zero immediately; stray data ignored; first request addr=RESET_PC. If FETCH_PERF_CNT_EN is defined, fetch_cnt/flush_cnt=0 after reset.
